seq_det_scheduler: RTL

SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

---
 rtl/seq_det_scheduler_pkg.sv | 10 +
 rtl/seq_det_next_len.sv | 54 +++++
 rtl/seq_det_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/seq_det_scheduler_pkg.sv
// Shared constants and types for the time-multiplexed 4-channel sequence detector.
// Holds channel count, context width, default pattern and round-robin pointer type.
package seq_det_scheduler_pkg;
    localparam int         NUM_CH      = 4;
    localparam int         CTX_W       = 2;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    typedef logic [1:0]       rr_ptr_t;
    typedef logic [CTX_W-1:0] ctx_t;
endpackage

// File: rtl/seq_det_next_len.sv
// Next match-length and match flag for one accepted bit against a 4-bit pattern.
// Purely combinational, no latency and no backpressure.
module seq_det_next_len
    import seq_det_scheduler_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEF_PATTERN,
    parameter bit         OVERLAP = 1'b0
) (
    input  logic [CTX_W-1:0] len_i,
    input  logic             bit_i,
    output logic [CTX_W-1:0] next_len_o,
    output logic             match_o
);

    logic [4:0] hist;
    logic [4:0] mask;
    logic [2:0] best;
    ctx_t       border;

    // The matched prefix is PATTERN's top len bits, so history is rebuilt from it.
    always_comb begin
        hist = 5'(PATTERN >> (4 - int'(len_i)));
        hist = {hist[3:0], bit_i};
        mask = '0;
        best = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= int'(len_i) + 1) begin
                mask = 5'((1 << k) - 1);
                if ((hist & mask) == 5'(PATTERN >> (4 - k))) begin
                    best = 3'(k);
                end
            end
        end
    end

    // Longest proper border of PATTERN, the restart point for overlapping mode.
    always_comb begin
        border = '0;
        for (int k = 1; k <= 3; k++) begin
            if ((PATTERN & 4'((1 << k) - 1)) == (PATTERN >> (4 - k))) begin
                border = ctx_t'(k);
            end
        end
    end

    always_comb begin
        match_o    = (best == 3'd4);
        next_len_o = best[1:0];
        if (match_o) begin
            next_len_o = OVERLAP ? border : '0;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one sequence detector across 4 serial channels.
// det_valid 1 cycle after the accepting edge; one grant per cycle, others hold their bit.
module seq_det_scheduler
    import seq_det_scheduler_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEF_PATTERN,
    parameter bit         OVERLAP = 1'b0,
    parameter int         CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [3:0]        ch_valid,
    input  logic [3:0]        ch_bit,
    output logic [3:0]        ch_ready,
    output logic              det_valid,
    output logic [1:0]        det_ch,
    input  logic [1:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_cnt
);

    ctx_t             ctx_q [NUM_CH];
    ctx_t             ctx_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    rr_ptr_t          ptr_q, ptr_d;
    logic             det_valid_q, det_valid_d;
    logic [1:0]       det_ch_q, det_ch_d;

    rr_ptr_t          cand;
    rr_ptr_t          grant_idx;
    logic             grant_vld;
    logic             xfer;
    ctx_t             nl_len;
    logic             nl_match;

    always_comb begin
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = ptr_q + rr_ptr_t'(i);
            if (!grant_vld && ch_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign xfer     = enable & ~clear & grant_vld;
    assign ch_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

    seq_det_next_len #(
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_next_len (
        .len_i      (ctx_q[grant_idx]),
        .bit_i      (ch_bit[grant_idx]),
        .next_len_o (nl_len),
        .match_o    (nl_match)
    );

    always_comb begin
        ctx_d       = ctx_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_d[i] = '0;
                cnt_d[i] = '0;
            end
            ptr_d    = '0;
            det_ch_d = '0;
        end else if (xfer) begin
            ctx_d[grant_idx] = nl_len;
            ptr_d            = grant_idx + 2'd1;
            if (nl_match) begin
                det_valid_d = 1'b1;
                det_ch_d    = grant_idx;
                if (cnt_q[grant_idx] != {CNT_W{1'b1}}) begin
                    cnt_d[grant_idx] = cnt_q[grant_idx] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            ctx_q       <= ctx_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign rd_cnt    = cnt_q[rd_sel];

endmodule
